// File: rtl/aes_msg_sequencer_pkg.sv
// Shared constants, FSM encodings and command payload for the AES message sequencer.
package aes_msg_sequencer_pkg;

  localparam int unsigned BLOCK_BYTES     = 16;
  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned WORDS_PER_BLOCK = BLOCK_BYTES / WORD_BYTES;
  localparam int unsigned IDX_W           = 2;
  localparam int unsigned BCNT_W          = 3;
  localparam int unsigned FSIZE_W         = 8;
  localparam int unsigned DEF_LEN_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_FILL     = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_OUTPUT   = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CMD_INIT = 2'd0,
    CMD_NEXT = 2'd1,
    CMD_FIN  = 2'd2
  } cmd_e;

  typedef struct packed {
    logic init;
    logic next;
    logic finalize;
  } aes_cmd_t;

  // Keep the first nbytes bytes (MSB first) of a word, zero the rest.
  function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] w,
                                                  input logic [BCNT_W-1:0] nbytes);
    logic [WORD_W-1:0] m;
    case (nbytes)
      3'd0:    m = 32'h0000_0000;
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      3'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return w & m;
  endfunction

endpackage

// File: rtl/aes_msg_sequencer_block_packer.sv
// Assembles 32-bit words into a zero-masked 128-bit block; word 0 lands in [127:96].
module aes_block_packer
  import aes_msg_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [IDX_W-1:0]   word_idx_i,
  input  logic [BCNT_W-1:0]  byte_cnt_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [BLOCK_W-1:0] block_o
);

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [WORD_W-1:0]  masked;

  assign masked = mask_word(word_i, byte_cnt_i);

  // Clear wins over load so a fresh block never inherits stale words.
  always_comb begin
    block_d = block_q;
    if (clear_i) begin
      block_d = '0;
    end else if (load_i) begin
      case (word_idx_i)
        2'd0:    block_d[127:96] = masked;
        2'd1:    block_d[95:64]  = masked;
        2'd2:    block_d[63:32]  = masked;
        default: block_d[31:0]   = masked;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) block_q <= '0;
    else          block_q <= block_d;
  end

  assign block_o = block_q;

endmodule

// File: rtl/aes_msg_sequencer.sv
// Feeds a length-tagged word stream to the AES CTR/CMAC wrapper block by block and
// returns ciphertext blocks or the CMAC tag on a valid/ready stream.
module aes_msg_sequencer
  import aes_msg_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_start,
  input  logic               cfg_enc_auth,
  input  logic [LEN_W-1:0]   cfg_msg_len,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               aes_init,
  output logic               aes_next,
  output logic               aes_finalize,
  output logic               aes_enc_auth,
  output logic [FSIZE_W-1:0] aes_final_size,
  output logic [BLOCK_W-1:0] aes_block,
  input  logic               aes_ready,
  input  logic [BLOCK_W-1:0] aes_block_o,
  output logic [BLOCK_W-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  localparam logic [LEN_W-1:0] BLK_LEN  = LEN_W'(BLOCK_BYTES);
  localparam logic [LEN_W-1:0] WORD_LEN = LEN_W'(WORD_BYTES);

  state_e             state_q, state_d;
  cmd_e               last_cmd_q, last_cmd_d;
  aes_cmd_t           cmd_q, cmd_d;
  logic               mode_q, mode_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic               first_q, first_d;
  logic [FSIZE_W-1:0] fsize_q, fsize_d;
  logic [BLOCK_W-1:0] m_data_q, m_data_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   word_off, rem_left;
  logic [BCNT_W-1:0]  byte_cnt;
  logic               last_word, issue_next, enter_issue;
  logic               pk_clear, pk_load;

  // Per-word view of the current block: bytes still owed and whether this word closes it.
  always_comb begin
    word_off   = LEN_W'({widx_q, 2'b00});
    rem_left   = rem_q - word_off;
    byte_cnt   = (rem_left >= WORD_LEN) ? BCNT_W'(WORD_BYTES) : rem_left[BCNT_W-1:0];
    last_word  = (rem_left <= WORD_LEN) || (widx_q == IDX_W'(WORDS_PER_BLOCK - 1));
    issue_next = rem_q > BLK_LEN;
  end

  always_comb begin
    state_d     = state_q;
    last_cmd_d  = last_cmd_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    widx_d      = widx_q;
    first_d     = 1'b0;
    fsize_d     = fsize_q;
    m_data_d    = m_data_q;
    pk_clear    = 1'b0;
    pk_load     = 1'b0;
    cmd_d       = '0;
    enter_issue = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          mode_d   = cfg_enc_auth;
          rem_d    = cfg_msg_len;
          fsize_d  = '0;
          widx_d   = '0;
          pk_clear = 1'b1;
          // An empty CTR message has nothing to encrypt: skip the wrapper entirely.
          if (!cfg_enc_auth && (cfg_msg_len == '0)) state_d = ST_DONE;
          else                                      state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        last_cmd_d = CMD_INIT;
        first_d    = 1'b1;
        state_d    = ST_WAIT_CMD;
      end
      ST_WAIT_CMD: begin
        // The wrapper's ready may still reflect the previous command for one cycle.
        if (!first_q && aes_ready) begin
          case (last_cmd_q)
            CMD_INIT: state_d = (rem_q == '0) ? ST_ISSUE : ST_FILL;
            CMD_NEXT: state_d = mode_q ? ST_FILL : ST_OUTPUT;
            default:  state_d = ST_OUTPUT;
          endcase
          if (state_d == ST_OUTPUT) m_data_d = aes_block_o;
        end
      end
      ST_FILL: begin
        if (s_valid) begin
          pk_load = 1'b1;
          if (last_word) begin
            widx_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            widx_d = widx_q + IDX_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        first_d = 1'b1;
        state_d = ST_WAIT_CMD;
        if (issue_next) begin
          rem_d      = rem_q - BLK_LEN;
          last_cmd_d = CMD_NEXT;
        end else begin
          rem_d      = '0;
          last_cmd_d = CMD_FIN;
        end
      end
      ST_OUTPUT: begin
        if (m_ready) state_d = (rem_q != '0) ? ST_FILL : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_FILL) && (state_q != ST_FILL)) pk_clear = 1'b1;

    // Command pulses and final_size are decoded one cycle ahead so they register in with the state.
    enter_issue    = (state_d == ST_ISSUE) && (state_q != ST_ISSUE);
    cmd_d.init     = (state_d == ST_INIT) && (state_q != ST_INIT);
    cmd_d.next     = enter_issue && issue_next;
    cmd_d.finalize = enter_issue && !issue_next;
    if (cmd_d.finalize) fsize_d = FSIZE_W'({rem_q[4:0], 3'b000});

    s_ready_d = (state_d == ST_FILL);
    m_valid_d = (state_d == ST_OUTPUT);
    m_last_d  = (state_d == ST_OUTPUT) && (rem_d == '0);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      last_cmd_q <= CMD_INIT;
      cmd_q      <= '0;
      mode_q     <= 1'b0;
      rem_q      <= '0;
      widx_q     <= '0;
      first_q    <= 1'b0;
      fsize_q    <= '0;
      m_data_q   <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cmd_q <= last_cmd_d;
      cmd_q      <= cmd_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      widx_q     <= widx_d;
      first_q    <= first_d;
      fsize_q    <= fsize_d;
      m_data_q   <= m_data_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  aes_block_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (pk_clear),
    .load_i     (pk_load),
    .word_idx_i (widx_q),
    .byte_cnt_i (byte_cnt),
    .word_i     (s_data),
    .block_o    (aes_block)
  );

  assign s_ready        = s_ready_q;
  assign aes_init       = cmd_q.init;
  assign aes_next       = cmd_q.next;
  assign aes_finalize   = cmd_q.finalize;
  assign aes_enc_auth   = mode_q;
  assign aes_final_size = fsize_q;
  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
